// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the PC fetch stage.
// PCSrc selects and fetch FSM states.
package pc_fetch_unit_pkg;

  localparam logic [1:0] PCS_PLUS4 = 2'b00;
  localparam logic [1:0] PCS_REL   = 2'b01;
  localparam logic [1:0] PCS_JALR  = 2'b10;
  localparam logic [1:0] PCS_RSVD  = 2'b11;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

endpackage

// File: rtl/pc_target_gen.sv
// Next-PC target computation.
// Three adders, a select mux and an alignment check.
module pc_target_gen
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic [31:0] pc_plus4,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] rel_sum;
  logic [31:0] jalr_sum;
  logic [31:0] jalr_tgt;

  assign pc_plus4 = pc + 32'd4;
  assign rel_sum  = pc + imm;
  assign jalr_sum = rs1 + imm;
  assign jalr_tgt = {jalr_sum[31:1], 1'b0};

  // Select the target; only redirects can be misaligned.
  always_comb begin
    target     = pc_plus4;
    misaligned = 1'b0;
    unique case (pcsrc)
      PCS_REL: begin
        target     = rel_sum;
        misaligned = |rel_sum[1:0];
      end
      PCS_JALR: begin
        target     = jalr_tgt;
        misaligned = jalr_tgt[1];
      end
      PCS_PLUS4: begin
        target     = pc_plus4;
        misaligned = 1'b0;
      end
      PCS_RSVD: begin
        target     = pc_plus4;
        misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, fetch handshake and misaligned-target trap.
// A faulting redirect spends one cycle in TRAP before the trap vector.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0040_0100
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ExtImm,
  input  logic [31:0] RS1,
  input  logic        Stall,
  input  logic        IAck,
  output logic [31:0] PC,
  output logic [31:0] PC_Plus4,
  output logic        IReq,
  output logic        Misaligned,
  output logic [31:0] BadAddr,
  output logic [31:0] InstrCount
);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] bad_q;
  logic [31:0] bad_d;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic        mis_q;
  logic        mis_d;
  logic [31:0] target;
  logic        tgt_mis;
  logic        advance;

  pc_target_gen u_tgt (
    .pc         (pc_q),
    .pcsrc      (PCSrc),
    .imm        (ExtImm),
    .rs1        (RS1),
    .pc_plus4   (PC_Plus4),
    .target     (target),
    .misaligned (tgt_mis)
  );

  // Fetch request is held low during reset and the trap cycle.
  assign IReq = (state_q == ST_RUN) && !RESET;

  assign advance = (state_q == ST_RUN) && IReq
                && IAck && !Stall;

  // State register and architectural registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VECTOR;
      bad_q   <= 32'd0;
      cnt_q   <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state, next-PC, retire count and trap capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bad_d   = bad_q;
    cnt_d   = cnt_q;
    mis_d   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (advance) begin
          if (tgt_mis) begin
            bad_d   = target;
            mis_d   = 1'b1;
            state_d = ST_TRAP;
          end else begin
            pc_d  = target;
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      ST_TRAP: begin
        pc_d    = TRAP_VECTOR;
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign PC         = pc_q;
  assign BadAddr    = bad_q;
  assign InstrCount = cnt_q;
  assign Misaligned = mis_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter stage directly downstream of the conditional/PC-select logic.
- Consumes the 2-bit PCSrc decision together with the immediate and rs1 operands, computes the next PC, and holds it in the PC register.
- Drives the instruction-memory fetch request with a req/ack handshake and honours pipeline stalls.
- Detects misaligned control-transfer targets and redirects to a trap vector through a one-cycle trap state.

Parameters:
- RESET_VECTOR, 32'h00400000, PC value loaded on reset.
- TRAP_VECTOR, 32'h00400100, PC loaded after a misaligned-target trap.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- PCSrc  in  2  next-PC select: 00 = PC+4; 01 = PC+ExtImm (taken branch / jal); 10 = (RS1+ExtImm) & ~1 (jalr); 11 = reserved, treated as 00.
- ExtImm  in  32  sign-extended immediate of the current instruction.
- RS1  in  32  rs1 register value, used for jalr.
- Stall  in  1  hold the PC and retire nothing this cycle.
- IAck  in  1  instruction memory has returned the instruction at PC this cycle.
- PC  out  32  current fetch address.
- PC_Plus4  out  32  PC+4, combinational; used as the jal/jalr link value.
- IReq  out  1  fetch request for address PC.
- Misaligned  out  1  one-cycle pulse when a misaligned target is detected.
- BadAddr  out  32  registered copy of the last misaligned target.
- InstrCount  out  32  count of retired instructions.

Behaviour:
- Reset (async, while RESET=1): PC=RESET_VECTOR, state=RUN, BadAddr=0, InstrCount=0, Misaligned=0. IReq=0 while RESET is high; IReq rises in the first cycle after RESET deasserts.
- Target computation (combinational, 32-bit, wrap-around modulo 2^32, no overflow detection):
  - T00 = PC+4.
  - T01 = PC+ExtImm.
  - T10 = (RS1+ExtImm) with bit 0 forced to 0.
  - PCSrc=11 behaves exactly as 00.
- Misaligned = selected target bit[1]=1 (or bit[0]=1 for 01); checked only for PCSrc 01/10. PC+4 is always aligned.
- Advance condition: state=RUN && IReq && IAck && !Stall.
- State RUN:
  - IReq=1.
  - On advance with aligned target: PC <= target; InstrCount <= InstrCount+1 (wraps 0xFFFFFFFF -> 0).
  - On advance with misaligned target: PC unchanged; BadAddr <= target; Misaligned=1 for that cycle; InstrCount unchanged (faulting instruction is not retired); state -> TRAP.
  - No advance (IAck=0 or Stall=1): PC, InstrCount and state hold. PCSrc is ignored; no redirect is buffered.
- State TRAP (exactly one cycle): IReq=0; PC <= TRAP_VECTOR; state -> RUN. Stall and IAck are ignored in TRAP.
- Simultaneous Stall=1 and IAck=1: Stall wins; the instruction is refetched (IReq stays 1 with the same PC).
- Misaligned is a registered pulse aligned with the cycle the state is TRAP. Equivalently: asserted for exactly the one cycle following the faulting advance edge.
- RESET mid-trap or mid-stall: immediate return to reset values; no trap completion.
- Output latency: PC changes one clock after the advance cycle. PC_Plus4 follows PC combinationally.

Decomposition:
- Shared package: PCSrc encodings (PCS_PLUS4=2'b00, PCS_REL=2'b01, PCS_JALR=2'b10, PCS_RSVD=2'b11) and state encodings (ST_RUN, ST_TRAP). The existing PC_Logic uses the same PCSrc constants.
- One natural sub-module: pc_target_gen, purely combinational (three adders, mux, alignment check). The top level holds the FSM, PC register, BadAddr and counter.

Test Plan:
- Reset and sequential fetch: release RESET, PCSrc=00, IAck=1, Stall=0 for 3 cycles -> PC sequence 0x00400000, 0x00400004, 0x00400008, 0x0040000C; InstrCount=3.
- Taken branch with wrap and stall: at PC=0x00400010, ExtImm=0xFFFFFFF0, PCSrc=01, with Stall=1 for 2 cycles then 0 -> PC holds 0x00400010 during the stall, then becomes 0x00400000; InstrCount increments by 1 only.
- jalr bit-0 clear: RS1=0x00400021, ExtImm=0x00000003, PCSrc=10 -> PC=0x00400024 (0x24, bit 0 cleared; aligned, no trap); PC_Plus4 before the update = old PC+4.
- Misaligned jalr: RS1=0x00400022, ExtImm=0, PCSrc=10 -> Misaligned=1 for one cycle, BadAddr=0x00400022, IReq=0 for one cycle, then PC=0x00400100; InstrCount unchanged.
- Memory wait and reserved select: IAck=0 for 4 cycles with PCSrc=01 -> PC frozen, IReq=1 throughout. Then PCSrc=11 with IAck=1 -> PC advances by 4.
- Reset mid-trap: assert RESET during the TRAP cycle -> PC immediately 0x00400000, Misaligned=0, BadAddr=0, InstrCount=0, IReq=0.
